// File: rtl/pipeio_pkg.sv
// Shared register map, status bit positions and sizing helper for the
// pipelined-CPU I/O responder.
package pipeio_pkg;

    localparam logic [3:0] OFF_IN0    = 4'd0;
    localparam logic [3:0] OFF_IN1    = 4'd1;
    localparam logic [3:0] OFF_STATUS = 4'd2;
    localparam logic [3:0] OFF_IRQEN  = 4'd3;
    localparam logic [3:0] OFF_OUT0   = 4'd4;
    localparam logic [3:0] OFF_OUT1   = 4'd5;
    localparam logic [3:0] OFF_OUT2   = 4'd6;
    localparam logic [3:0] OFF_OUT3   = 4'd7;

    localparam int STAT_CHG0 = 0;
    localparam int STAT_CHG1 = 1;

    function automatic int cnt_width(input int debounce);
        return $clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/pipeio_debounce.sv
// Two-flop synchronizer plus stability counter for one raw switch port;
// commit is a strobe for the edge at which the committed value updates.
module pipeio_debounce
    import pipeio_pkg::*;
#(
    parameter int IN_W     = 6,
    parameter int DEBOUNCE = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IN_W-1:0] raw_in,
    output logic [IN_W-1:0] value,
    output logic            commit
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [IN_W-1:0]  sync1_r;
    logic [IN_W-1:0]  sync2_r;
    logic [IN_W-1:0]  value_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             commit_s;

    // Counter restarts whenever the synchronized value is about to move.
    always_comb begin
        cnt_next_s = '0;
        commit_s   = 1'b0;
        if (sync1_r != sync2_r) begin
            cnt_next_s = '0;
        end else if (sync2_r == value_r) begin
            cnt_next_s = '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_next_s = '0;
            commit_s   = 1'b1;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Synchronizer, counter and committed value.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
            value_r <= '0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= raw_in;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_next_s;
            if (commit_s) begin
                value_r <= sync2_r;
            end else begin
                value_r <= value_r;
            end
        end
    end

    assign value  = value_r;
    assign commit = commit_s;

endmodule

// File: rtl/pipeio_responder.sv
// MEM-stage I/O window: word-wide register file with output strobes,
// debounced input ports, sticky change flags and a level interrupt.
module pipeio_responder
    import pipeio_pkg::*;
#(
    parameter int          IN_W     = 6,
    parameter int          DEBOUNCE = 16,
    parameter logic [31:0] IO_BASE  = 32'h0000_0080
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic            we,
    input  logic            re,
    output logic [31:0]     rdata,
    output logic            io_sel,
    input  logic [IN_W-1:0] in_port0,
    input  logic [IN_W-1:0] in_port1,
    output logic [31:0]     out_port0,
    output logic [31:0]     out_port1,
    output logic [31:0]     out_port2,
    output logic [31:0]     out_port3,
    output logic [3:0]      out_strobe,
    output logic            irq
);

    logic            io_sel_s;
    logic [3:0]      off_s;
    logic [IN_W-1:0] in0_s;
    logic [IN_W-1:0] in1_s;
    logic [1:0]      commit_s;
    logic [3:0]      wr_onehot_s;
    logic            irqen_wr_s;
    logic            status_rd_s;
    logic [31:0]     rdata_s;
    logic            unused_addr_s;

    logic [31:0]     out_r [4];
    logic [3:0]      strobe_r;
    logic [1:0]      irqen_r;
    logic [1:0]      chg_r;

    assign io_sel_s      = (addr[31:6] == IO_BASE[31:6]);
    assign off_s         = addr[5:2];
    assign unused_addr_s = ^addr[1:0];

    pipeio_debounce #(.IN_W(IN_W), .DEBOUNCE(DEBOUNCE)) u_deb0 (
        .clock  (clock),
        .reset  (reset),
        .raw_in (in_port0),
        .value  (in0_s),
        .commit (commit_s[STAT_CHG0])
    );

    pipeio_debounce #(.IN_W(IN_W), .DEBOUNCE(DEBOUNCE)) u_deb1 (
        .clock  (clock),
        .reset  (reset),
        .raw_in (in_port1),
        .value  (in1_s),
        .commit (commit_s[STAT_CHG1])
    );

    // Store decode: one-hot output-port select and IRQEN write enable.
    always_comb begin
        wr_onehot_s = 4'b0000;
        irqen_wr_s  = 1'b0;
        if (we && io_sel_s) begin
            case (off_s)
                OFF_OUT0:  wr_onehot_s = 4'b0001;
                OFF_OUT1:  wr_onehot_s = 4'b0010;
                OFF_OUT2:  wr_onehot_s = 4'b0100;
                OFF_OUT3:  wr_onehot_s = 4'b1000;
                OFF_IRQEN: irqen_wr_s  = 1'b1;
                default:   wr_onehot_s = 4'b0000;
            endcase
        end else begin
            wr_onehot_s = 4'b0000;
        end
    end

    assign status_rd_s = re && io_sel_s && (off_s == OFF_STATUS);

    // Register file, strobes and sticky flags; a new change beats a clearing read.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                out_r[i] <= 32'd0;
            end
            strobe_r <= 4'b0000;
            irqen_r  <= 2'b00;
            chg_r    <= 2'b00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_onehot_s[i]) begin
                    out_r[i] <= wdata;
                end else begin
                    out_r[i] <= out_r[i];
                end
            end
            strobe_r <= wr_onehot_s;
            if (irqen_wr_s) begin
                irqen_r <= wdata[1:0];
            end else begin
                irqen_r <= irqen_r;
            end
            chg_r <= commit_s | (chg_r & ~{2{status_rd_s}});
        end
    end

    // Load mux over registered state; outside the window the bus reads zero.
    always_comb begin
        rdata_s = 32'd0;
        if (io_sel_s) begin
            case (off_s)
                OFF_IN0:    rdata_s = {{(32-IN_W){1'b0}}, in0_s};
                OFF_IN1:    rdata_s = {{(32-IN_W){1'b0}}, in1_s};
                OFF_STATUS: rdata_s = {30'd0, chg_r};
                OFF_IRQEN:  rdata_s = {30'd0, irqen_r};
                OFF_OUT0:   rdata_s = out_r[0];
                OFF_OUT1:   rdata_s = out_r[1];
                OFF_OUT2:   rdata_s = out_r[2];
                OFF_OUT3:   rdata_s = out_r[3];
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign rdata      = rdata_s;
    assign io_sel     = io_sel_s;
    assign out_port0  = out_r[0];
    assign out_port1  = out_r[1];
    assign out_port2  = out_r[2];
    assign out_port3  = out_r[3];
    assign out_strobe = strobe_r;
    assign irq        = |(chg_r & irqen_r);

endmodule

// File: tb/tb_pipeio_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a
// sample-window reference model of the I/O responder.
module tb_pipeio_responder;

    localparam int D = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        io_sel;
    logic [5:0]  in_port0;
    logic [5:0]  in_port1;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [31:0] out_port2;
    logic [31:0] out_port3;
    logic [3:0]  out_strobe;
    logic        irq;

    always #5 clock = ~clock;

    pipeio_responder #(.IN_W(6), .DEBOUNCE(D), .IO_BASE(32'h0000_0080)) dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .re         (re),
        .rdata      (rdata),
        .io_sel     (io_sel),
        .in_port0   (in_port0),
        .in_port1   (in_port1),
        .out_port0  (out_port0),
        .out_port1  (out_port1),
        .out_port2  (out_port2),
        .out_port3  (out_port3),
        .out_strobe (out_strobe),
        .irq        (irq)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: committed values change once the last D+1 raw samples agree.
    logic [31:0] m_out [4];
    logic [1:0]  m_irqen;
    logic [1:0]  m_chg;
    logic [3:0]  m_strobe;
    logic [5:0]  m_cin  [2];
    logic [5:0]  m_runv [2];
    int          m_runl [2];

    logic [31:0] last_rdata;
    logic        last_irq;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_sel(input logic [31:0] a);
        return (a >> 6) == (32'h0000_0080 >> 6);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int o;
        o = int'(a[5:2]);
        if (!m_sel(a)) return 32'd0;
        if (o == 0) return {26'd0, m_cin[0]};
        if (o == 1) return {26'd0, m_cin[1]};
        if (o == 2) return {30'd0, m_chg};
        if (o == 3) return {30'd0, m_irqen};
        if (o >= 4 && o <= 7) return m_out[o-4];
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_out[i] = 32'd0;
        m_irqen  = 2'b00;
        m_chg    = 2'b00;
        m_strobe = 4'b0000;
        for (int p = 0; p < 2; p++) begin
            m_cin[p]  = 6'd0;
            m_runv[p] = 6'd0;
            m_runl[p] = D + 1;
        end
    endtask

    // One clock cycle: drive, check against model, advance model, clock.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic r, input logic rs);
        logic [5:0] raw [2];
        logic [1:0] com;
        int         o;
        addr = a; wdata = d; we = w; re = r; reset = rs;
        #1;
        last_rdata = rdata;
        last_irq   = irq;
        check_val("io_sel", {31'd0, io_sel}, {31'd0, m_sel(a)});
        check_val("rdata", rdata, m_read(a));
        check_val("irq", {31'd0, irq}, {31'd0, |(m_chg & m_irqen)});
        check_val("out0", out_port0, m_out[0]);
        check_val("out1", out_port1, m_out[1]);
        check_val("out2", out_port2, m_out[2]);
        check_val("out3", out_port3, m_out[3]);
        check_val("strobe", {28'd0, out_strobe}, {28'd0, m_strobe});
        raw[0] = in_port0;
        raw[1] = in_port1;
        if (rs) begin
            m_reset();
        end else begin
            o   = int'(a[5:2]);
            com = 2'b00;
            for (int p = 0; p < 2; p++) begin
                if (m_runl[p] >= D + 1 && m_runv[p] != m_cin[p]) begin
                    com[p]   = 1'b1;
                    m_cin[p] = m_runv[p];
                end
            end
            m_chg    = com | ((m_sel(a) && r && o == 2) ? 2'b00 : m_chg);
            m_strobe = 4'b0000;
            if (w && m_sel(a)) begin
                if (o >= 4 && o <= 7) begin
                    m_out[o-4]    = d;
                    m_strobe[o-4] = 1'b1;
                end else if (o == 3) begin
                    m_irqen = d[1:0];
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (raw[p] == m_runv[p]) begin
                    if (m_runl[p] < 1000) m_runl[p]++;
                end else begin
                    m_runv[p] = raw[p];
                    m_runl[p] = 1;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    // Reads an address each cycle until it returns v; reports the cycle index.
    task automatic wait_read(input string tag, input logic [31:0] a,
                             input logic [31:0] v, input int exp_cyc);
        int found;
        found = -1;
        for (int i = 0; i < 60 && found < 0; i++) begin
            cycle(a, 32'd0, 1'b0, 1'b0, 1'b0);
            if (last_rdata == v) found = i;
        end
        check_val(tag, 32'(found), 32'(exp_cyc));
    endtask

    initial begin
        int          nz;
        int          found;
        logic [31:0] a;
        reset = 1'b1; addr = 32'd0; wdata = 32'd0; we = 1'b0; re = 1'b0;
        in_port0 = 6'd0; in_port1 = 6'd0;
        repeat (3) @(negedge clock);
        m_reset();

        // Output port write, strobe and readback.
        cycle(32'h90, 32'h0000_003F, 1'b1, 1'b0, 1'b0);
        check_val("strobe_after_wr", {28'd0, out_strobe}, 32'h1);
        cycle(32'h90, 32'd0, 1'b0, 1'b1, 1'b0);
        check_val("out0_readback", last_rdata, 32'h3F);
        check_val("strobe_one_cycle", {28'd0, out_strobe}, 32'h0);

        // Debounce latency on IN0.
        in_port0 = 6'h15;
        wait_read("in0_latency", 32'h80, 32'h15, 18);
        cycle(32'h88, 32'd0, 1'b0, 1'b1, 1'b0);
        check_val("status_chg0", last_rdata, 32'h1);

        // Bouncing input never commits; the settled value does after 18 cycles.
        nz = 0;
        for (int k = 0; k < 20; k++) begin
            in_port1 = (k % 2 == 0) ? 6'h15 : 6'h00;
            for (int j = 0; j < 5; j++) begin
                cycle(32'h84, 32'd0, 1'b0, 1'b0, 1'b0);
                if (last_rdata != 32'd0) nz++;
            end
        end
        check_val("toggle_no_commit", 32'(nz), 32'd0);
        in_port1 = 6'h2A;
        wait_read("in1_latency", 32'h84, 32'h2A, 18);
        cycle(32'h88, 32'd0, 1'b0, 1'b1, 1'b0);
        check_val("status_chg1", last_rdata, 32'h2);

        // Interrupt rises with the commit and falls after the STATUS read.
        cycle(32'h8C, 32'h1, 1'b1, 1'b0, 1'b0);
        in_port0 = 6'h0A;
        found = -1;
        for (int i = 0; i < 40 && found < 0; i++) begin
            cycle(32'h80, 32'd0, 1'b0, 1'b0, 1'b0);
            if (last_irq === 1'b1) found = i;
        end
        check_val("irq_latency", 32'(found), 32'd18);
        check_val("in0_at_irq", last_rdata, 32'h0A);
        cycle(32'h88, 32'd0, 1'b0, 1'b1, 1'b0);
        check_val("status_irq", last_rdata, 32'h1);
        cycle(32'h88, 32'd0, 1'b0, 1'b0, 1'b0);
        check_val("irq_cleared", {31'd0, last_irq}, 32'd0);
        check_val("chg0_cleared", last_rdata, 32'd0);

        // Commit coincides with a STATUS read: pre-clear value returned, set wins.
        in_port0 = 6'h33;
        for (int i = 0; i < 17; i++) cycle(32'h80, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(32'h88, 32'd0, 1'b0, 1'b1, 1'b0);
        check_val("status_race_rd", last_rdata, 32'd0);
        cycle(32'h88, 32'd0, 1'b0, 1'b0, 1'b0);
        check_val("status_race_set", last_rdata, 32'h1);
        check_val("irq_race", {31'd0, last_irq}, 32'd1);

        // Reset during a write and mid-debounce.
        in_port1 = 6'h03;
        for (int i = 0; i < 8; i++) cycle(32'h84, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(32'hA0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        check_val("rst_out0", out_port0, 32'd0);
        check_val("rst_strobe", {28'd0, out_strobe}, 32'd0);
        wait_read("rst_latency", 32'h84, 32'h03, 18);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 24) == 0) in_port0 = 6'($urandom);
            if ($urandom_range(0, 24) == 0) in_port1 = 6'($urandom);
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = 32'h80 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            cycle(a, $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
